// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a 1-cycle-latency FIFO into a valid/ready stream via a 2-entry skid buffer,
// counting accepted beats and latching FIFO read errors.
module fifo_rd_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             flush_i,
    input  logic             fifo_empty_i,
    input  logic [WIDTH-1:0] fifo_rdata_i,
    input  logic             fifo_rd_error_i,
    output logic             fifo_rd_en_o,
    output logic [WIDTH-1:0] m_data_o,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [CNT_W-1:0] xfer_cnt_o,
    output logic             err_o
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_t;
    occ_t occ, occ_n;
    logic inflight, pop, push;
    logic [WIDTH-1:0] slot1;
    logic [2:0] load;
    assign m_valid_o = occ != EMPTY;
    assign pop = m_valid_o & m_ready_i;
    assign push = inflight & ~flush_i;
    // words held or arriving after this cycle's pop; a new read needs a free slot for it
    assign load = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_rd_en_o = rst_i & en_i & ~flush_i & ~fifo_empty_i & (load <= 3'd1);
    always_comb begin
        occ_n = occ;
        if (flush_i) occ_n = EMPTY;
        else begin
            case (occ)
                EMPTY:   occ_n = push ? ONE : EMPTY;
                ONE:     occ_n = (push & ~pop) ? TWO : (pop & ~push) ? EMPTY : ONE;
                TWO:     occ_n = pop ? ONE : TWO;
                default: occ_n = EMPTY;
            endcase
        end
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            occ        <= EMPTY;
            inflight   <= 1'b0;
            m_data_o   <= '0;
            slot1      <= '0;
            xfer_cnt_o <= '0;
            err_o      <= 1'b0;
        end else begin
            occ        <= occ_n;
            inflight   <= fifo_rd_en_o;
            xfer_cnt_o <= xfer_cnt_o + CNT_W'(pop);
            err_o      <= err_o | fifo_rd_error_i;
            if (push && (occ == EMPTY || (occ == ONE && pop))) m_data_o <= fifo_rdata_i;
            else if (occ == TWO && pop) m_data_o <= slot1;
            if (push && occ == ONE && !pop) slot1 <= fifo_rdata_i;
        end
    end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: drives fifo_rd_stream from a queue-based FIFO model and checks every cycle
// against a scoreboard of words read but not yet consumed.
module tb_fifo_rd_stream;
    logic clk_i = 0, rst_i = 0, en_i = 0, flush_i = 0, fifo_empty_i = 1, fifo_rd_error_i = 0, m_ready_i = 0;
    logic [7:0] fifo_rdata_i = 0;
    logic fifo_rd_en_o, m_valid_o, err_o, rd_en4, valid4, err4;
    logic [7:0] m_data_o, data4;
    logic [15:0] xfer_cnt_o;
    logic [3:0] cnt4;
    int tests = 0, fails = 0;
    byte unsigned fifo_q[$], exp_q[$];
    bit pend, err_m;
    logic [7:0] pend_w;
    int cnt, reads;

    always #5 clk_i = ~clk_i;

    fifo_rd_stream #(.WIDTH(8), .CNT_W(16)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .flush_i(flush_i),
        .fifo_empty_i(fifo_empty_i), .fifo_rdata_i(fifo_rdata_i), .fifo_rd_error_i(fifo_rd_error_i),
        .fifo_rd_en_o(fifo_rd_en_o), .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
        .xfer_cnt_o(xfer_cnt_o), .err_o(err_o));

    fifo_rd_stream #(.WIDTH(8), .CNT_W(4)) u_dut4 (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .flush_i(flush_i),
        .fifo_empty_i(fifo_empty_i), .fifo_rdata_i(fifo_rdata_i), .fifo_rd_error_i(fifo_rd_error_i),
        .fifo_rd_en_o(rd_en4), .m_data_o(data4), .m_valid_o(valid4), .m_ready_i(m_ready_i),
        .xfer_cnt_o(cnt4), .err_o(err4));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wr(input int n);
        repeat (n) fifo_q.push_back(8'($urandom));
        fifo_empty_i = fifo_q.size() == 0;
    endtask

    // one clock: compare at negedge, advance the model at posedge, FIFO answers 1 after the edge
    task automatic cyc();
        bit pop, rd;
        @(negedge clk_i);
        pop = exp_q.size() != 0 && m_ready_i;
        rd = rst_i && en_i && !flush_i && fifo_q.size() != 0 && (exp_q.size() + int'(pend) - int'(pop) <= 1);
        chk("valid", 32'(m_valid_o), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) chk("data", 32'(m_data_o), 32'(exp_q[0]));
        chk("rd_en", 32'(fifo_rd_en_o), 32'(rd));
        chk("rd_en4", 32'(rd_en4), 32'(rd));
        chk("xfer_cnt", 32'(xfer_cnt_o), 32'(cnt & 16'hffff));
        chk("xfer_cnt4", 32'(cnt4), 32'(cnt & 4'hf));
        chk("err", 32'(err_o), 32'(err_m));
        @(posedge clk_i);
        if (pop) begin
            void'(exp_q.pop_front());
            cnt++;
        end
        if (flush_i) exp_q.delete();
        else if (pend) exp_q.push_back(pend_w);
        if (fifo_rd_error_i) err_m = 1;
        pend = rd;
        if (rd) begin
            pend_w = fifo_q.pop_front();
            reads++;
        end
        #1;
        fifo_rdata_i = rd ? pend_w : 8'($urandom);
        fifo_empty_i = fifo_q.size() == 0;
    endtask

    task automatic do_reset();
        rst_i = 0;
        #1;
        chk("rst_valid", 32'(m_valid_o), 0);
        chk("rst_data", 32'(m_data_o), 0);
        chk("rst_cnt", 32'(xfer_cnt_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_rd_en", 32'(fifo_rd_en_o), 0);
        exp_q.delete();
        fifo_q.delete();
        pend = 0; cnt = 0; err_m = 0; reads = 0;
        fifo_empty_i = 1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #6;
        en_i = 1;
        do_reset();
        // T1: reach two buffered words, then reset asynchronously
        m_ready_i = 0;
        wr(5);
        repeat (4) cyc();
        chk("t1_reads", 32'(reads), 2);
        chk("t1_valid", 32'(m_valid_o), 1);
        do_reset();
        repeat (3) cyc();
        // first-word latency: issue cycle, capture cycle
        wr(1);
        cyc();
        chk("lat_issue", 32'(m_valid_o), 0);
        cyc();
        chk("lat_capture", 32'(m_valid_o), 1);
        m_ready_i = 1;
        repeat (2) cyc();
        // T2: full-rate streaming
        do_reset();
        m_ready_i = 1;
        wr(16);
        repeat (2) cyc();
        for (int i = 0; i < 16; i++) begin
            chk("t2_consecutive", 32'(m_valid_o), 1);
            cyc();
        end
        chk("t2_cnt", 32'(xfer_cnt_o), 16);
        chk("t2_cnt4", 32'(cnt4), 0);
        chk("t2_fifo_empty", 32'(fifo_empty_i), 1);
        chk("t2_err", 32'(err_o), 0);
        // T3: alternating back-pressure
        do_reset();
        wr(16);
        for (int i = 0; i < 50; i++) begin
            m_ready_i = ~m_ready_i;
            cyc();
        end
        chk("t3_cnt", 32'(xfer_cnt_o), 16);
        // T4: stall with five words queued
        do_reset();
        m_ready_i = 0;
        wr(5);
        repeat (10) cyc();
        chk("t4_reads", 32'(reads), 2);
        chk("t4_left", 32'(fifo_q.size()), 3);
        m_ready_i = 1;
        repeat (8) cyc();
        chk("t4_cnt", 32'(xfer_cnt_o), 5);
        // T5: flush with a word in flight, then flush with two buffered and a pop
        do_reset();
        m_ready_i = 0;
        wr(8);
        repeat (2) cyc();
        flush_i = 1;
        cyc();
        flush_i = 0;
        chk("t5_valid_a", 32'(m_valid_o), 0);
        chk("t5_cnt_a", 32'(xfer_cnt_o), 0);
        repeat (4) cyc();
        chk("t5_two", 32'(m_valid_o), 1);
        m_ready_i = 1;
        flush_i = 1;
        cyc();
        flush_i = 0;
        chk("t5_valid_b", 32'(m_valid_o), 0);
        chk("t5_cnt_b", 32'(xfer_cnt_o), 1);
        repeat (10) cyc();
        // T6: counter wrap and sticky error
        do_reset();
        m_ready_i = 1;
        wr(17);
        repeat (20) cyc();
        chk("t6_cnt4", 32'(cnt4), 1);
        chk("t6_cnt", 32'(xfer_cnt_o), 17);
        fifo_rd_error_i = 1;
        cyc();
        fifo_rd_error_i = 0;
        repeat (5) cyc();
        chk("t6_err", 32'(err_o), 1);
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0) wr($urandom_range(4));
            en_i = $urandom_range(4) != 0;
            m_ready_i = $urandom_range(1);
            flush_i = $urandom_range(30) == 0;
            fifo_rd_error_i = $urandom_range(200) == 0;
            cyc();
        end
        flush_i = 0;
        fifo_rd_error_i = 0;
        do_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
